// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and the writeback entry layout for the regfile writeback arbiter.
// Writes to register index zero are filtered out before they reach the queue or the port.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int QDEPTH_DEF = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Result-source and regfile-write-port bundle for the writeback arbiter.
// The slave modport is the arbiter's side; the master side drives results and watches the port.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
);
    logic                     a_valid;
    logic [ADDR_W-1:0]        a_reg;
    logic [DATA_W-1:0]        a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [ADDR_W-1:0]        b_reg;
    logic [DATA_W-1:0]        b_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_reg;
    logic [DATA_W-1:0]        wb_data;
    logic                     busy;
    logic [$clog2(QDEPTH):0]  q_count;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  b_ready, wb_en, wb_reg, wb_data, busy, q_count
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output b_ready, wb_en, wb_reg, wb_data, busy, q_count
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_squash_fifo.sv
// Circular buffer of writeback entries with per-entry valid bits.
// A squash clears the valid bit of every stored entry whose tag matches; the slot stays occupied.
module wb_squash_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = QDEPTH_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_reg_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              squash_i,
    input  logic [ADDR_W-1:0] squash_reg_i,
    output logic              head_present_o,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_reg_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o
);
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] reg_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                cnt_q, cnt_d;

    // Squash before push so an entry landing at this edge keeps its valid bit.
    always_comb begin
        vld_d = vld_q;
        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_q[i] == squash_reg_i) vld_d[i] = 1'b0;
            end
        end
        if (push_i) vld_d[wr_ptr_q] = 1'b1;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_q    <= '0;
            reg_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            if (push_i) begin
                reg_q[wr_ptr_q] <= push_reg_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) data_q[wr_ptr_q] <= push_data_i;
    end

    assign head_present_o = (cnt_q != '0);
    assign head_valid_o   = vld_q[rd_ptr_q];
    assign head_reg_o     = reg_q[rd_ptr_q];
    assign head_data_o    = data_q[rd_ptr_q];
    assign count_o        = cnt_q;
    assign full_o         = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU results always win the regfile write port, mult/div results
// wait in a squashable queue and drain in acceptance order whenever the ALU is idle.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input logic                 clk,
    input logic                 clr,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic              a_live, b_push, pop, full;
    logic              head_present, head_valid;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     count;

    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    assign a_live      = bus.a_valid && (bus.a_reg != ADDR_W'(REG_ZERO));
    // Ready looks at occupancy only; a pop at the same edge does not free a slot early.
    assign bus.b_ready = !clr && !full;
    assign b_push      = bus.b_valid && bus.b_ready && (bus.b_reg != ADDR_W'(REG_ZERO));
    assign pop         = !a_live && head_present;

    wb_squash_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (QDEPTH)
    ) u_fifo (
        .clk            (clk),
        .clr            (clr),
        .push_i         (b_push),
        .push_reg_i     (bus.b_reg),
        .push_data_i    (bus.b_data),
        .pop_i          (pop),
        .squash_i       (a_live),
        .squash_reg_i   (bus.a_reg),
        .head_present_o (head_present),
        .head_valid_o   (head_valid),
        .head_reg_o     (head_reg),
        .head_data_o    (head_data),
        .count_o        (count),
        .full_o         (full)
    );

    always_comb begin
        wb_en_d   = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        if (a_live) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = bus.a_reg;
            wb_data_d = bus.a_data;
        end else if (pop && head_valid) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = head_reg;
            wb_data_d = head_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.wb_en   = wb_en_q;
    assign bus.wb_reg  = wb_reg_q;
    assign bus.wb_data = wb_data_q;
    assign bus.busy    = head_present;
    assign bus.q_count = count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus directed multi-cycle sequences,
// with every regfile write checked against a queue of expected writes.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .QDEPTH(4)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .QDEPTH(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        en;
        logic [4:0]  er;
        logic [31:0] ed;
        logic [2:0]  cnt;
    } vec_t;

    vec_t      tbl [9];
    wb_entry_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sbpush(input logic [4:0] r, input logic [31:0] d);
        wb_entry_t e;
        e.valid = 1'b1;
        e.rd    = r;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_reg   = ar;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_reg   = br;
        bus.b_data  = bd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every regfile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb unexpected write: got r%0d=%0h expected no write", bus.wb_reg, bus.wb_data);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                chk("sb wb_reg", 32'(bus.wb_reg), 32'(e.rd));
                chk("sb wb_data", bus.wb_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 3'd0};
        tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  32'hDEADBEEF, 3'd0};
        tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 3'd0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 32'hFFFFFFFF, 3'd0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,       1'b0, 5'd31, 32'hFFFFFFFF, 3'd0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0C0FFEE0, 1'b0, 5'd31, 32'hFFFFFFFF, 3'd1};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0C0FFEE0, 3'd0};
        tbl[7] = '{1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,        1'b1, 5'd1,  32'h1,        3'd1};
        tbl[8] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'h2,        3'd0};

        idle();
        #2;
        chk("reset wb_en", 32'(bus.wb_en), 32'd0);
        chk("reset wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("reset wb_data", bus.wb_data, 32'd0);
        chk("reset q_count", 32'(bus.q_count), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset b_ready", 32'(bus.b_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        tick();
        chk("post-reset b_ready", 32'(bus.b_ready), 32'd1);
        chk("post-reset wb_en", 32'(bus.wb_en), 32'd0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
            if (tbl[i].en) sbpush(tbl[i].er, tbl[i].ed);
            tick();
            chk($sformatf("vec%0d wb_en", i), 32'(bus.wb_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d wb_reg", i), 32'(bus.wb_reg), 32'(tbl[i].er));
            chk($sformatf("vec%0d wb_data", i), bus.wb_data, tbl[i].ed);
            chk($sformatf("vec%0d q_count", i), 32'(bus.q_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(tbl[i].cnt != 3'd0));
            chk($sformatf("vec%0d b_ready", i), 32'(bus.b_ready), 32'd1);
        end
        idle();
        tick();

        // A busy for 4 cycles while B queues r3..r5, then B drains back to back.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd10, 32'hA0 + 32'(i), (i < 3), 5'(3 + i), 32'h303 + 32'(i));
            sbpush(5'd10, 32'hA0 + 32'(i));
            tick();
        end
        chk("starve q_count", 32'(bus.q_count), 32'd3);
        chk("starve busy", 32'(bus.busy), 32'd1);
        idle();
        for (int j = 0; j < 3; j++) begin
            sbpush(5'(3 + j), 32'h303 + 32'(j));
            tick();
            chk($sformatf("drain%0d wb_en", j), 32'(bus.wb_en), 32'd1);
            chk($sformatf("drain%0d wb_reg", j), 32'(bus.wb_reg), 32'(3 + j));
            chk($sformatf("drain%0d q_count", j), 32'(bus.q_count), 32'(2 - j));
        end
        tick();

        // Full queue: ready drops, and a pop does not admit a new entry at the same edge.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd10, 32'h100 + 32'(i), 1'b1, 5'(i + 1), 32'h201 + 32'(i));
            sbpush(5'd10, 32'h100 + 32'(i));
            tick();
        end
        chk("full q_count", 32'(bus.q_count), 32'd4);
        chk("full b_ready", 32'(bus.b_ready), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
        sbpush(5'd1, 32'h201);
        tick();
        chk("full pop q_count", 32'(bus.q_count), 32'd3);
        chk("full pop b_ready", 32'(bus.b_ready), 32'd1);
        sbpush(5'd2, 32'h202);
        tick();
        chk("full push+pop q_count", 32'(bus.q_count), 32'd3);
        idle();
        sbpush(5'd3, 32'h203);
        tick();
        chk("full drain q_count2", 32'(bus.q_count), 32'd2);
        sbpush(5'd4, 32'h204);
        tick();
        chk("full drain q_count1", 32'(bus.q_count), 32'd1);
        sbpush(5'd6, 32'h66);
        tick();
        chk("full drain q_count0", 32'(bus.q_count), 32'd0);
        chk("full drain wb_reg", 32'(bus.wb_reg), 32'd6);
        tick();

        // Squash: r7 queued behind r8 is overridden by a newer A write to r7.
        drive(1'b1, 5'd15, 32'hF0, 1'b1, 5'd8, 32'h8);
        sbpush(5'd15, 32'hF0);
        tick();
        drive(1'b1, 5'd15, 32'hF1, 1'b1, 5'd7, 32'h1);
        sbpush(5'd15, 32'hF1);
        tick();
        drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0);
        sbpush(5'd7, 32'h2);
        tick();
        chk("squash q_count", 32'(bus.q_count), 32'd2);
        idle();
        sbpush(5'd8, 32'h8);
        tick();
        chk("squash r8 wb_en", 32'(bus.wb_en), 32'd1);
        chk("squash r8 wb_reg", 32'(bus.wb_reg), 32'd8);
        chk("squash r8 busy", 32'(bus.busy), 32'd1);
        tick();
        chk("squash bubble wb_en", 32'(bus.wb_en), 32'd0);
        chk("squash bubble wb_data", bus.wb_data, 32'h8);
        chk("squash bubble q_count", 32'(bus.q_count), 32'd0);
        chk("squash bubble busy", 32'(bus.busy), 32'd0);
        tick();

        // Same-edge A write and B enqueue to r9: B entry survives and lands second.
        drive(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'hAA);
        sbpush(5'd9, 32'h11);
        tick();
        chk("same-edge q_count", 32'(bus.q_count), 32'd1);
        chk("same-edge a data", bus.wb_data, 32'h11);
        idle();
        sbpush(5'd9, 32'hAA);
        tick();
        chk("same-edge b wb_en", 32'(bus.wb_en), 32'd1);
        chk("same-edge b wb_data", bus.wb_data, 32'hAA);
        chk("same-edge b q_count", 32'(bus.q_count), 32'd0);
        tick();

        // Asynchronous clear with three entries pending drops them all.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd20, 32'hC0 + 32'(i), 1'b1, 5'(21 + i), 32'hD0 + 32'(i));
            sbpush(5'd20, 32'hC0 + 32'(i));
            tick();
        end
        chk("clr pre q_count", 32'(bus.q_count), 32'd3);
        idle();
        @(negedge clk);
        #1 clr = 1'b1;
        #1;
        chk("clr wb_en", 32'(bus.wb_en), 32'd0);
        chk("clr q_count", 32'(bus.q_count), 32'd0);
        chk("clr busy", 32'(bus.busy), 32'd0);
        chk("clr b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        chk("clr held wb_en", 32'(bus.wb_en), 32'd0);
        clr = 1'b0;
        tick();
        chk("clr release b_ready", 32'(bus.b_ready), 32'd1);
        chk("clr release wb_en", 32'(bus.wb_en), 32'd0);
        chk("clr release q_count", 32'(bus.q_count), 32'd0);
        tick();
        tick();
        chk("clr after wb_en", 32'(bus.wb_en), 32'd0);
        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
